// File: rtl/var_delay_buffer.sv
// Runtime-programmable multi-lane delay line (1..DEPTH cycles) with a shared valid flag.
// Optional DLYBUF_ERR_EN adds o_dly_err, a one-cycle pulse flagging a clamped delay request.
module var_delay_buffer #(
  parameter int BW          = 16,
  parameter int CH          = 1,
  parameter int DEPTH       = 32,
  parameter int DEFAULT_DLY = 32,
  parameter int DW          = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ce,
  input  logic [CH*BW-1:0] i_data,
  input  logic             i_signal,
  input  logic             i_dly_load,
  input  logic [DW-1:0]    i_dly,
  output logic [CH*BW-1:0] o_data,
  output logic             o_signal,
  output logic             o_busy,
  output logic [DW-1:0]    o_dly
`ifdef DLYBUF_ERR_EN
  ,
  output logic             o_dly_err
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [DW-1:0]   cnt_reg, cnt_next;
  logic [DW-1:0]   dly_reg, dly_next;
  logic [DW-1:0]   dly_clamped;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic            wr_en;
  logic            out_en;

  always_comb begin
    dly_clamped = i_dly;
    if (i_dly == '0) begin
      dly_clamped = DW'(1);
    end else if (i_dly > DW'(DEPTH)) begin
      dly_clamped = DW'(DEPTH);
    end
  end

  // A load always wins over the countdown, so a load during SETTLE restarts it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dly_next   = dly_reg;
    if (i_ce) begin
      if (i_dly_load) begin
        state_next = ST_SETTLE;
        cnt_next   = dly_clamped;
        dly_next   = dly_clamped;
      end else if (state_reg == ST_SETTLE) begin
        if (cnt_reg == DW'(1)) begin
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt_reg - DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_SETTLE;
      cnt_reg    <= DW'(DEFAULT_DLY);
      dly_reg    <= DW'(DEFAULT_DLY);
      wr_ptr_reg <= AW'(1);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dly_reg   <= dly_next;
      if (i_ce) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
    end
  end

  // The reset cycle's sample lands at address 0 so the post-reset stream starts from it.
  assign wr_en   = rst | i_ce;
  assign wr_addr = rst ? '0 : wr_ptr_reg;
  // D == DEPTH aliases the write slot; read-before-write returns the oldest entry.
  assign rd_addr = wr_ptr_reg - dly_reg[AW-1:0];
  assign out_en  = (state_next == ST_RUN);

  logic sig_mem [DEPTH];
  logic sig_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      sig_mem[wr_addr] <= i_signal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_reg <= 1'b0;
    end else if (i_ce) begin
      sig_reg <= out_en ? sig_mem[rd_addr] : 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_lane
      logic [BW-1:0] mem [DEPTH];
      logic [BW-1:0] data_reg;

      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[wr_addr] <= i_data[gi*BW +: BW];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (i_ce) begin
          data_reg <= out_en ? mem[rd_addr] : '0;
        end
      end

      assign o_data[gi*BW +: BW] = data_reg;
    end
  endgenerate

  assign o_signal = sig_reg;
  assign o_busy   = (state_reg == ST_SETTLE);
  assign o_dly    = dly_reg;

`ifdef DLYBUF_ERR_EN
  logic dly_bad;
  logic dly_err_reg;

  assign dly_bad = (i_dly == '0) || (i_dly > DW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_err_reg <= 1'b0;
    end else begin
      dly_err_reg <= i_ce & i_dly_load & dly_bad;
    end
  end

  assign o_dly_err = dly_err_reg;
`endif

endmodule

// File: tb/tb_var_delay_buffer.sv
// Directed bench for var_delay_buffer: reset, loads, wrap, reload, clock-enable hold, clamping.
// Input sample n carries data n; expected outputs follow from the sample index and delay.
module tb_var_delay_buffer;

  localparam int BW          = 16;
  localparam int CH          = 1;
  localparam int DEPTH       = 32;
  localparam int DEFAULT_DLY = 32;
  localparam int DW          = $clog2(DEPTH) + 1;
  localparam int DATA_W      = CH * BW;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_ce;
  logic [DATA_W-1:0] i_data;
  logic              i_signal;
  logic              i_dly_load;
  logic [DW-1:0]     i_dly;
  logic [DATA_W-1:0] o_data;
  logic              o_signal;
  logic              o_busy;
  logic [DW-1:0]     o_dly;
`ifdef DLYBUF_ERR_EN
  logic              o_dly_err;
`endif

  int   total = 0;
  int   bad   = 0;
  int   seq   = 0;
  logic sig_hist [0:4095];

  var_delay_buffer #(
    .BW(BW), .CH(CH), .DEPTH(DEPTH), .DEFAULT_DLY(DEFAULT_DLY)
  ) dut (
    .clk(clk), .rst(rst), .i_ce(i_ce), .i_data(i_data), .i_signal(i_signal),
    .i_dly_load(i_dly_load), .i_dly(i_dly), .o_data(o_data), .o_signal(o_signal),
    .o_busy(o_busy), .o_dly(o_dly)
`ifdef DLYBUF_ERR_EN
    , .o_dly_err(o_dly_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic sig);
    i_data        = DATA_W'(seq);
    i_signal      = sig;
    sig_hist[seq] = sig;
  endtask

  task automatic advance(input bit alt);
    seq++;
    put(alt ? seq[0] : 1'b1);
  endtask

  task automatic test_reset();
    logic [DATA_W+1:0] got, want;
    int e;
    rst = 1'b1; i_ce = 1'b1; i_dly_load = 1'b0; i_dly = '0;
    seq = 0; put(1'b1);
    tick();
    $display("reset applied: busy=%0d sig=%0d data=%0h dly=%0d", o_busy, o_signal, o_data, o_dly);
    got = {o_busy, o_signal, o_data}; want = {1'b1, 1'b0, DATA_W'(0)};
    total++;
    if (got !== want) begin bad++; $display("FAIL reset_outputs: got %0h want %0h", got, want); end
    total++;
    if (o_dly !== DW'(DEFAULT_DLY)) begin bad++; $display("FAIL reset_dly: got %0d want %0d", o_dly, DEFAULT_DLY); end
    rst = 1'b0;
    advance(1'b0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      e = seq;
      got = {o_busy, o_signal, o_data};
      if (k < DEFAULT_DLY) want = {1'b1, 1'b0, DATA_W'(0)};
      else                 want = {1'b0, 1'b1, DATA_W'(e - DEFAULT_DLY)};
      total++;
      if (got !== want) begin bad++; $display("FAIL reset_stream k=%0d: got %0h want %0h", k, got, want); end
      advance(1'b0);
    end
  endtask

  task automatic test_load_run();
    logic [DATA_W+1:0] got, want;
    int e;
    $display("load dly=5 at sample %0d", seq);
    i_dly_load = 1'b1; i_dly = DW'(5);
    for (int k = 0; k < 16; k++) begin
      tick();
      i_dly_load = 1'b0;
      e = seq;
      if (k == 0) begin
        total++;
        if (o_dly !== DW'(5)) begin bad++; $display("FAIL load5_dly: got %0d want 5", o_dly); end
      end
      got = {o_busy, o_signal, o_data};
      if (k < 5) want = {1'b1, 1'b0, DATA_W'(0)};
      else       want = {1'b0, sig_hist[e-5], DATA_W'(e - 5)};
      total++;
      if (got !== want) begin bad++; $display("FAIL load5_stream k=%0d: got %0h want %0h", k, got, want); end
      advance(1'b1);
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W+1:0] got, want;
    int e;
    $display("load dly=1 at sample %0d", seq);
    i_dly_load = 1'b1; i_dly = DW'(1);
    for (int k = 0; k < 20; k++) begin
      tick();
      i_dly_load = 1'b0;
      e = seq;
      if (k == 0) begin
        total++;
        if (o_dly !== DW'(1)) begin bad++; $display("FAIL wrap_dly1: got %0d want 1", o_dly); end
      end
      got = {o_busy, o_signal, o_data};
      if (k < 1) want = {1'b1, 1'b0, DATA_W'(0)};
      else       want = {1'b0, sig_hist[e-1], DATA_W'(e - 1)};
      total++;
      if (got !== want) begin bad++; $display("FAIL wrap_lag1 k=%0d: got %0h want %0h", k, got, want); end
      advance(1'b1);
    end
    $display("load dly=%0d at sample %0d", DEPTH, seq);
    i_dly_load = 1'b1; i_dly = DW'(DEPTH);
    for (int k = 0; k < 4 * DEPTH + 8; k++) begin
      tick();
      i_dly_load = 1'b0;
      e = seq;
      got = {o_busy, o_signal, o_data};
      if (k < DEPTH) want = {1'b1, 1'b0, DATA_W'(0)};
      else           want = {1'b0, sig_hist[e-DEPTH], DATA_W'(e - DEPTH)};
      total++;
      if (got !== want) begin bad++; $display("FAIL wrap_lag32 k=%0d: got %0h want %0h", k, got, want); end
      advance(1'b1);
    end
  endtask

  task automatic test_reload();
    logic [DATA_W+1:0] got, want;
    int e;
    $display("load dly=8 then dly=3 two cycles later at sample %0d", seq);
    i_dly_load = 1'b1; i_dly = DW'(8);
    for (int k = 0; k < 14; k++) begin
      tick();
      i_dly_load = (k == 1);
      i_dly      = DW'(3);
      e = seq;
      if (k == 0) begin
        total++;
        if (o_dly !== DW'(8)) begin bad++; $display("FAIL reload_dly8: got %0d want 8", o_dly); end
      end
      if (k == 2) begin
        total++;
        if (o_dly !== DW'(3)) begin bad++; $display("FAIL reload_dly3: got %0d want 3", o_dly); end
      end
      got = {o_busy, o_signal, o_data};
      if (k < 5) want = {1'b1, 1'b0, DATA_W'(0)};
      else       want = {1'b0, sig_hist[e-3], DATA_W'(e - 3)};
      total++;
      if (got !== want) begin bad++; $display("FAIL reload_stream k=%0d: got %0h want %0h", k, got, want); end
      advance(1'b1);
    end
    i_dly_load = 1'b0;
  endtask

  task automatic test_ce_hold();
    logic [DATA_W+1:0] got, want;
    int e;
    int last;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = seq;
      got = {o_busy, o_signal, o_data}; want = {1'b0, sig_hist[e-3], DATA_W'(e - 3)};
      total++;
      if (got !== want) begin bad++; $display("FAIL ce_pre k=%0d: got %0h want %0h", k, got, want); end
      advance(1'b1);
    end
    last = seq - 1;
    $display("clock enable low for 4 cycles after sample %0d", last);
    i_ce = 1'b0; i_data = DATA_W'(16'hBEEF); i_signal = ~sig_hist[seq]; i_dly = DW'(7);
    for (int h = 0; h < 4; h++) begin
      i_dly_load = (h == 1);
      tick();
      got = {o_busy, o_signal, o_data}; want = {1'b0, sig_hist[last-3], DATA_W'(last - 3)};
      total++;
      if (got !== want) begin bad++; $display("FAIL ce_hold h=%0d: got %0h want %0h", h, got, want); end
      total++;
      if (o_dly !== DW'(3)) begin bad++; $display("FAIL ce_hold_dly h=%0d: got %0d want 3", h, o_dly); end
    end
    i_ce = 1'b1; i_dly_load = 1'b0;
    put(seq[0]);
    for (int k = 0; k < 8; k++) begin
      tick();
      e = seq;
      got = {o_busy, o_signal, o_data}; want = {1'b0, sig_hist[e-3], DATA_W'(e - 3)};
      total++;
      if (got !== want) begin bad++; $display("FAIL ce_resume k=%0d: got %0h want %0h", k, got, want); end
      advance(1'b1);
    end
  endtask

  task automatic test_clamp();
    logic [DATA_W+1:0] got, want;
    int e;
    $display("load dly=0 at sample %0d", seq);
    i_dly_load = 1'b1; i_dly = DW'(0);
    for (int k = 0; k < 5; k++) begin
      tick();
      i_dly_load = 1'b0;
      e = seq;
      if (k == 0) begin
        total++;
        if (o_dly !== DW'(1)) begin bad++; $display("FAIL clamp_zero_dly: got %0d want 1", o_dly); end
      end
`ifdef DLYBUF_ERR_EN
      total++;
      if (o_dly_err !== (k == 0)) begin bad++; $display("FAIL clamp_zero_err k=%0d: got %0d want %0d", k, o_dly_err, (k == 0)); end
`endif
      got = {o_busy, o_signal, o_data};
      if (k < 1) want = {1'b1, 1'b0, DATA_W'(0)};
      else       want = {1'b0, sig_hist[e-1], DATA_W'(e - 1)};
      total++;
      if (got !== want) begin bad++; $display("FAIL clamp_zero_stream k=%0d: got %0h want %0h", k, got, want); end
      advance(1'b1);
    end
    $display("load dly=40 at sample %0d", seq);
    i_dly_load = 1'b1; i_dly = DW'(40);
    for (int k = 0; k < 3; k++) begin
      tick();
      i_dly_load = 1'b0;
      total++;
      if (o_dly !== DW'(DEPTH)) begin bad++; $display("FAIL clamp_high_dly k=%0d: got %0d want %0d", k, o_dly, DEPTH); end
`ifdef DLYBUF_ERR_EN
      total++;
      if (o_dly_err !== (k == 0)) begin bad++; $display("FAIL clamp_high_err k=%0d: got %0d want %0d", k, o_dly_err, (k == 0)); end
`endif
      advance(1'b1);
    end
    $display("load dly=4 at sample %0d, then reset with a simultaneous load", seq);
    i_dly_load = 1'b1; i_dly = DW'(4);
    tick();
    i_dly_load = 1'b0;
    total++;
    if (o_dly !== DW'(4)) begin bad++; $display("FAIL legal_dly: got %0d want 4", o_dly); end
`ifdef DLYBUF_ERR_EN
    total++;
    if (o_dly_err !== 1'b0) begin bad++; $display("FAIL legal_err: got %0d want 0", o_dly_err); end
`endif
    advance(1'b1);
    tick();
    advance(1'b1);
    rst = 1'b1; i_dly_load = 1'b1; i_dly = DW'(5);
    tick();
    rst = 1'b0; i_dly_load = 1'b0;
    got = {o_busy, o_signal, o_data}; want = {1'b1, 1'b0, DATA_W'(0)};
    total++;
    if (got !== want) begin bad++; $display("FAIL midreset_outputs: got %0h want %0h", got, want); end
    total++;
    if (o_dly !== DW'(DEFAULT_DLY)) begin bad++; $display("FAIL midreset_dly: got %0d want %0d", o_dly, DEFAULT_DLY); end
    advance(1'b1);
    for (int k = 1; k <= DEFAULT_DLY + 3; k++) begin
      tick();
      e = seq;
      got = {o_busy, o_signal, o_data};
      if (k < DEFAULT_DLY) want = {1'b1, 1'b0, DATA_W'(0)};
      else                 want = {1'b0, sig_hist[e-DEFAULT_DLY], DATA_W'(e - DEFAULT_DLY)};
      total++;
      if (got !== want) begin bad++; $display("FAIL midreset_stream k=%0d: got %0h want %0h", k, got, want); end
      advance(1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_wrap();
    test_reload();
    test_ce_hold();
    test_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
